gpc607_accum: RTL and testbench

GPC607_ACCUM -- requirements
Module: gpc607_accum

---
 rtl/gpc_pkg.sv | 6 +
 rtl/gpc607_5.sv | 21 ++
 rtl/gpc607_accum.sv | 99 +++++++++
 tb/tb_gpc607_accum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gpc_pkg.sv
// rtl/gpc_pkg.sv - shared widths for the 7/6 generalized parallel counter
package gpc_pkg;
  localparam int GPC_IN0_W = 7;
  localparam int GPC_IN2_W = 6;
  localparam int GPC_OUT_W = 5;
endpackage

// File: rtl/gpc607_5.sv
// rtl/gpc607_5.sv - combinational (7,0,6;5) counter: popcount(src0) + 4*popcount(src2)
module gpc607_5
  import gpc_pkg::*;
(
  input  logic [GPC_IN0_W-1:0] src0,
  input  logic [GPC_IN2_W-1:0] src2,
  output logic [GPC_OUT_W-1:0] sum
);

  logic [2:0] c0;
  logic [2:0] c2;

  always_comb begin
    c0 = '0;
    c2 = '0;
    for (int i = 0; i < GPC_IN0_W; i++) c0 = c0 + {2'b00, src0[i]};
    for (int i = 0; i < GPC_IN2_W; i++) c2 = c2 + {2'b00, src2[i]};
    sum = {2'b00, c0} + {c2, 2'b00};
  end

endmodule

// File: rtl/gpc607_accum.sv
// rtl/gpc607_accum.sv - per-frame saturating accumulator of gpc607_5 beat values
module gpc607_accum
  import gpc_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [GPC_IN0_W-1:0] src0,
  input  logic [GPC_IN2_W-1:0] src2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  logic [GPC_OUT_W-1:0] beat_val;
  logic                 s1_valid;
  logic [GPC_OUT_W-1:0] s1_val;
  logic                 s1_last;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 s1_adv;
  logic                 accept;
  logic [ACC_W:0]       acc_sum;
  logic [CNT_W:0]       cnt_sum;
  logic [ACC_W-1:0]     acc_next;
  logic [CNT_W-1:0]     cnt_next;
  logic                 sat_hit;

  gpc607_5 u_gpc (
    .src0 (src0),
    .src2 (src2),
    .sum  (beat_val)
  );

  // Only a closing beat can stall, and only against an unconsumed result.
  assign s1_adv   = !(s1_valid && s1_last && out_valid && !out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_sum  = {1'b0, acc} + {{(ACC_W - GPC_OUT_W + 1){1'b0}}, s1_val};
    cnt_sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    sat_hit  = acc_sum[ACC_W] || cnt_sum[CNT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_val    <= '0;
      s1_last   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_val  <= beat_val;
          s1_last <= in_last;
        end
      end

      if (s1_valid && s1_adv && !s1_last) begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf || sat_hit;
      end

      // A fresh result takes priority over retiring the one being consumed.
      if (s1_valid && s1_adv && s1_last) begin
        out_sum   <= acc_next;
        out_count <= cnt_next;
        out_ovf   <= ovf || sat_hit;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpc607_accum.sv
// tb/tb_gpc607_accum.sv - directed self-checking bench for gpc607_accum
module tb_gpc607_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic [6:0]  src0;
  logic [5:0]  src2;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic [11:0] out_count;
  logic        out_ovf;

  logic        in_ready5;
  logic        out_valid5;
  logic [4:0]  out_sum5;
  logic [1:0]  out_count5;
  logic        out_ovf5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpc607_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .src0      (src0),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  gpc607_accum #(.ACC_W(5), .CNT_W(2)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready5),
    .in_last   (in_last),
    .src0      (src0),
    .src2      (src2),
    .out_valid (out_valid5),
    .out_ready (out_ready),
    .out_sum   (out_sum5),
    .out_count (out_count5),
    .out_ovf   (out_ovf5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [6:0] s0, input logic [5:0] s2, input logic last);
    in_valid = 1'b1;
    src0     = s0;
    src2     = s2;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [6:0]  v_s0  [4] = '{7'h30, 7'h10, 7'h62, 7'h1b};
  logic [5:0]  v_s2  [4] = '{6'h2b, 6'h1a, 6'h0e, 6'h00};
  logic [15:0] v_sum [4] = '{16'd18, 16'd13, 16'd15, 16'd4};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    src0 = '0; src2 = '0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_ovf", 32'(out_ovf), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // single-beat frame, result two edges after the beat is driven
    beat(7'h30, 6'h2b, 1'b1);
    check("single_lat1_valid", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_sum", 32'(out_sum), 18);
    check("single_count", 32'(out_count), 1);
    check("single_ovf", 32'(out_ovf), 0);
    tick();
    check("single_drain", 32'(out_valid), 0);

    // three-beat frame
    beat(7'h30, 6'h2b, 1'b0);
    beat(7'h10, 6'h1a, 1'b0);
    beat(7'h62, 6'h0e, 1'b1);
    tick();
    check("frame3_valid", 32'(out_valid), 1);
    check("frame3_sum", 32'(out_sum), 46);
    check("frame3_count", 32'(out_count), 3);
    check("frame3_ovf", 32'(out_ovf), 0);
    check("frame3_sum5_sat", 32'(out_sum5), 31);
    check("frame3_ovf5", 32'(out_ovf5), 1);
    tick();

    // sum saturation on the narrow instance, then a clean frame
    beat(7'h7f, 6'h3f, 1'b0);
    beat(7'h7f, 6'h3f, 1'b1);
    tick();
    check("sat_sum5", 32'(out_sum5), 31);
    check("sat_ovf5", 32'(out_ovf5), 1);
    check("sat_count5", 32'(out_count5), 2);
    check("sat_sum_wide", 32'(out_sum), 62);
    check("sat_ovf_wide", 32'(out_ovf), 0);
    beat(7'h30, 6'h2b, 1'b1);
    tick();
    check("after_sat_sum5", 32'(out_sum5), 18);
    check("after_sat_ovf5", 32'(out_ovf5), 0);
    tick();

    // count saturation: five zero beats on a 2-bit counter
    for (int i = 0; i < 5; i++) beat(7'h00, 6'h00, (i == 4));
    tick();
    check("cnt_sat_count5", 32'(out_count5), 3);
    check("cnt_sat_ovf5", 32'(out_ovf5), 1);
    check("cnt_wide_count", 32'(out_count), 5);
    check("cnt_wide_sum", 32'(out_sum), 0);
    tick();

    // backpressure with a second frame queued behind the held result
    out_ready = 1'b0;
    beat(7'h30, 6'h2b, 1'b1);
    beat(7'h1b, 6'h00, 1'b1);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_sum", 32'(out_sum), 18);
    check("bp_in_ready", 32'(in_ready), 0);
    tick();
    check("bp_sum_stable", 32'(out_sum), 18);
    check("bp_in_ready_hold", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(out_valid), 1);
    check("bp_next_sum", 32'(out_sum), 4);
    check("bp_next_count", 32'(out_count), 1);
    tick();
    check("bp_drain", 32'(out_valid), 0);

    // reset mid-frame discards the partial frame
    beat(7'h7f, 6'h3f, 1'b0);
    beat(7'h7f, 6'h3f, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_valid", 32'(out_valid), 0);
    beat(7'h26, 6'h01, 1'b1);
    check("midrst_no_out", 32'(out_valid), 0);
    tick();
    check("midrst_sum", 32'(out_sum), 7);
    check("midrst_count", 32'(out_count), 1);
    tick();

    // streaming one-beat frames at full rate
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_last = 1'b1;
        src0 = v_s0[i]; src2 = v_s2[i];
        check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
        check($sformatf("stream_sum_%0d", i), 32'(out_sum), 32'(v_sum[i-1]));
      end
    end
    check("stream_drain", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
